// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection,
// and frame-error detection with a break hold-off state.
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MAX  = TW'(DIV - 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]           r_sync;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_tcnt;
  logic [SW-1:0]        r_scnt;
  logic [BW-1:0]        r_bidx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;

  logic w_rx_s;
  logic w_timed;
  logic w_tick;

  assign w_rx_s  = r_sync[1];
  assign w_timed = (r_state == S_START) ||
                   (r_state == S_DATA)  ||
                   (r_state == S_STOP);
  assign w_tick  = w_timed && (r_tcnt == T_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // Divider is held at zero outside the timed states so the
  // tick phase is anchored to the detected start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (!w_timed || w_tick) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_scnt <= '0;
          r_bidx <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            if (r_scnt == S_HALF) begin
              r_scnt <= '0;
              r_bidx <= '0;
              r_state <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_scnt == S_MAX) begin
              r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_scnt  <= '0;
              if (r_bidx == B_LAST) begin
                r_bidx  <= '0;
                r_state <= S_STOP;
              end else begin
                r_bidx <= r_bidx + 1'b1;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_scnt == S_MAX) begin
              r_scnt <= '0;
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_BREAK;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule
